// File: rtl/counter_pkg.sv
// counter_pkg: shared mode/direction constants and sizing helper for counters
package counter_pkg;
  localparam bit SAT_WRAP = 1'b0;
  localparam bit SAT_HOLD = 1'b1;
  localparam bit DIR_DOWN = 1'b0;
  localparam bit DIR_UP = 1'b1;
  function automatic int clog2(input int v);
    int r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/en_prescaler.sv
// en_prescaler: divides enabled cycles by PRESCALE into single-cycle step ticks
module en_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick,
  output logic last
);
  localparam int PW = clog2(PRESCALE) < 1 ? 1 : clog2(PRESCALE);
  logic [PW-1:0] pcnt;
  assign last = pcnt == PW'(PRESCALE - 1);
  assign tick = en & last;
  always_ff @(posedge clk)
    pcnt <= (reset | clr | tick) ? '0 : en ? pcnt + PW'(1) : pcnt;
endmodule

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: modulus up/down counter with load, prescaled enable, wrap/saturate and flags
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MAX = 2**WIDTH - 1,
  parameter int PRESCALE = 1,
  parameter bit SATURATE = SAT_WRAP,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VAL);
  if (longint'(MAX) > (longint'(1) << WIDTH) - 1 || RESET_VAL > MAX || RESET_VAL < 0 || PRESCALE < 1 || WIDTH < 1) begin : g_bad_params
    $error("mod_updown_counter: illegal parameters");
  end
  logic step, last, up, at_bound, bound;
  logic [WIDTH-1:0] nxt, load_clamp;
  if (PRESCALE == 1) begin : g_nopre
    assign step = en;
    assign last = 1'b1;
  end else begin : g_pre
    en_prescaler #(.PRESCALE(PRESCALE)) u_pre (
      .clk(clk),
      .reset(reset),
      .clr(clear | load),
      .en(en),
      .tick(step),
      .last(last)
    );
  end
  always_comb begin
    up = dir == DIR_UP;
    at_bound = (dir == DIR_DOWN) ? count == '0 : count == MAX_W;
    bound = step & at_bound;
    nxt = bound ? ((SATURATE == SAT_HOLD) ? count : up ? '0 : MAX_W)
                : up ? count + WIDTH'(1) : count - WIDTH'(1);
    load_clamp = ({1'b0, load_val} > (WIDTH+1)'(MAX)) ? MAX_W : load_val;
    tc = en & last & at_bound & ~(reset | clear | load);
  end
  always_ff @(posedge clk)
    if (reset | clear) begin
      count <= RST_W;
      wrap <= 1'b0;
      ovf <= 1'b0;
    end else if (load) begin
      count <= load_clamp;
      wrap <= 1'b0;
    end else begin
      count <= step ? nxt : count;
      wrap <= bound;
      ovf <= ovf | bound;
    end
endmodule
